// File: rtl/cdc_tx_scheduler.sv
// Source-domain scheduler sharing one DATA_SYNC crossing between NUM_REQ requesters.
// Round-robin arbitration, then hold/gap sequencing of bus_enable around a stable word.
module cdc_tx_scheduler #(
   parameter int BUS         = 8,
   parameter int NUM_REQ     = 2,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   localparam int IDW        = $clog2(NUM_REQ)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*BUS-1:0] req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [BUS-1:0]         unsync_bus,
   output logic                   bus_enable,
   output logic [IDW-1:0]         grant_id,
   output logic                   busy,
   output logic                   xfer_done
);

   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;

   typedef enum logic [1:0] {IDLE, LOAD_HOLD, GAP} state_t;

   state_t              state;
   logic [CW-1:0]       counter;
   logic [IDW-1:0]      ptr;
   logic [IDW-1:0]      winner;
   logic [IDW-1:0]      offs;
   logic [IDW:0]        wsum;
   logic [2*NUM_REQ-1:0] rotated;
   logic [IDW-1:0]      ptr_next;
   logic                accept;

   // Rotate the valids so the pointer sits at bit 0; the lowest set bit is the winner's offset.
   always_comb begin
      rotated = {req_valid, req_valid} >> ptr;
      offs    = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         if (rotated[off]) offs = IDW'(off);
      end
      wsum = {1'b0, ptr} + {1'b0, offs};
      if (wsum >= (IDW+1)'(NUM_REQ)) wsum = wsum - (IDW+1)'(NUM_REQ);
      winner   = wsum[IDW-1:0];
      ptr_next = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
   end

   assign accept = (state == IDLE) && (|req_valid);
   assign busy   = (state != IDLE);

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[winner] = 1'b1;
   end

   // xfer_done is registered so it lines up with the final GAP cycle rather than trailing it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         counter    <= '0;
         ptr        <= '0;
         unsync_bus <= '0;
         bus_enable <= 1'b0;
         grant_id   <= '0;
         xfer_done  <= 1'b0;
      end else begin
         xfer_done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  unsync_bus <= req_data[winner*BUS +: BUS];
                  bus_enable <= 1'b1;
                  grant_id   <= winner;
                  ptr        <= ptr_next;
                  counter    <= CW'(HOLD_CYCLES - 1);
                  state      <= LOAD_HOLD;
               end
            end
            LOAD_HOLD: begin
               if (counter == '0) begin
                  bus_enable <= 1'b0;
                  counter    <= CW'(GAP_CYCLES - 1);
                  xfer_done  <= (GAP_CYCLES == 1);
                  state      <= GAP;
               end else begin
                  counter <= counter - CW'(1);
               end
            end
            GAP: begin
               if (counter == '0) begin
                  state <= IDLE;
               end else begin
                  counter   <= counter - CW'(1);
                  xfer_done <= (counter == CW'(1));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cdc_tx_scheduler.sv
// Directed bench for cdc_tx_scheduler: default instance plus a HOLD=1/GAP=1 boundary instance.
module tb_cdc_tx_scheduler;

   logic        CLK;
   logic        RST;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_ready;
   logic [7:0]  unsync_bus;
   logic        bus_enable;
   logic        grant_id;
   logic        busy;
   logic        xfer_done;

   logic [1:0]  req_valid_b;
   logic [15:0] req_data_b;
   logic [1:0]  req_ready_b;
   logic [7:0]  unsync_bus_b;
   logic        bus_enable_b;
   logic        grant_id_b;
   logic        busy_b;
   logic        xfer_done_b;

   int errors;
   int checks;

   cdc_tx_scheduler #(.BUS(8), .NUM_REQ(2), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
      .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
      .grant_id(grant_id), .busy(busy), .xfer_done(xfer_done)
   );

   cdc_tx_scheduler #(.BUS(8), .NUM_REQ(2), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_b (
      .CLK(CLK), .RST(RST), .req_valid(req_valid_b), .req_data(req_data_b),
      .req_ready(req_ready_b), .unsync_bus(unsync_bus_b), .bus_enable(bus_enable_b),
      .grant_id(grant_id_b), .busy(busy_b), .xfer_done(xfer_done_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge CLK);
      #1;
      req_valid   = 2'b00;
      req_valid_b = 2'b00;
      RST = 1'b1;
      #3;
      RST = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      RST = 1'b1;
      req_valid = 2'b00; req_data = 16'h0000;
      req_valid_b = 2'b00; req_data_b = 16'h0000;
      #2;
      checks++; if ({unsync_bus, bus_enable, grant_id, busy, xfer_done} !== 12'h000) begin
         errors++; $display("[TB] FAIL reset_outputs got bus=%h en=%b gid=%b busy=%b done=%b want all 0",
                            unsync_bus, bus_enable, grant_id, busy, xfer_done);
      end
      checks++; if (req_ready !== 2'b00) begin
         errors++; $display("[TB] FAIL reset_ready got %b want 00", req_ready);
      end
      #2 RST = 1'b0;
      tick();
   endtask

   task automatic test_single();
      pulse_reset();
      req_valid = 2'b01; req_data = 16'h00A5;
      #1;
      checks++; if (req_ready !== 2'b01) begin
         errors++; $display("[TB] FAIL single_ready got %b want 01", req_ready);
      end
      tick();
      req_valid = 2'b00;
      #1;
      checks++; if (unsync_bus !== 8'hA5 || grant_id !== 1'b0) begin
         errors++; $display("[TB] FAIL single_load got bus=%h gid=%b want A5/0", unsync_bus, grant_id);
      end
      for (int k = 1; k <= 9; k++) begin
         checks++; if (bus_enable !== (k <= 4)) begin
            errors++; $display("[TB] FAIL single_en cycle %0d got %b want %b", k, bus_enable, (k <= 4));
         end
         checks++; if (busy !== (k <= 6)) begin
            errors++; $display("[TB] FAIL single_busy cycle %0d got %b want %b", k, busy, (k <= 6));
         end
         checks++; if (xfer_done !== (k == 6)) begin
            errors++; $display("[TB] FAIL single_done cycle %0d got %b want %b", k, xfer_done, (k == 6));
         end
         checks++; if (req_ready !== 2'b00 || unsync_bus !== 8'hA5) begin
            errors++; $display("[TB] FAIL single_hold cycle %0d got ready=%b bus=%h want 00/A5", k, req_ready, unsync_bus);
         end
         tick();
      end
   endtask

   task automatic test_simultaneous();
      pulse_reset();
      req_valid = 2'b11; req_data = 16'h2211;
      #1;
      checks++; if (req_ready !== 2'b01) begin
         errors++; $display("[TB] FAIL simul_first_ready got %b want 01", req_ready);
      end
      tick();
      checks++; if (unsync_bus !== 8'h11 || grant_id !== 1'b0) begin
         errors++; $display("[TB] FAIL simul_first got bus=%h gid=%b want 11/0", unsync_bus, grant_id);
      end
      for (int k = 1; k <= 7; k++) begin
         checks++; if (bus_enable !== (k <= 4)) begin
            errors++; $display("[TB] FAIL simul_en cycle %0d got %b want %b", k, bus_enable, (k <= 4));
         end
         checks++; if (req_ready !== ((k == 7) ? 2'b10 : 2'b00)) begin
            errors++; $display("[TB] FAIL simul_ready cycle %0d got %b want %b", k, req_ready,
                               ((k == 7) ? 2'b10 : 2'b00));
         end
         if (k < 7) tick();
      end
      tick();
      checks++; if (unsync_bus !== 8'h22 || grant_id !== 1'b1 || bus_enable !== 1'b1) begin
         errors++; $display("[TB] FAIL simul_second got bus=%h gid=%b en=%b want 22/1/1",
                            unsync_bus, grant_id, bus_enable);
      end
      req_valid = 2'b00;
      repeat (7) tick();
   endtask

   task automatic test_rr_fairness();
      pulse_reset();
      req_valid = 2'b11; req_data = 16'hBBAA;
      #1;
      for (int t = 0; t < 6; t++) begin
         int w;
         w = 0;
         while (req_ready === 2'b00 && w < 20) begin
            tick();
            w++;
         end
         checks++; if (w !== ((t == 0) ? 0 : 6)) begin
            errors++; $display("[TB] FAIL rr_wait transfer %0d got %0d cycles want %0d", t, w, ((t == 0) ? 0 : 6));
         end
         checks++; if (req_ready !== ((t % 2 == 0) ? 2'b01 : 2'b10)) begin
            errors++; $display("[TB] FAIL rr_ready transfer %0d got %b want %b", t, req_ready,
                               ((t % 2 == 0) ? 2'b01 : 2'b10));
         end
         tick();
         checks++; if (grant_id !== 1'(t % 2)) begin
            errors++; $display("[TB] FAIL rr_grant transfer %0d got %b want %0d", t, grant_id, t % 2);
         end
      end
      req_valid = 2'b00;
      repeat (7) tick();
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      req_valid = 2'b10; req_data = 16'hC300;
      tick();
      req_valid = 2'b00;
      checks++; if (grant_id !== 1'b1 || bus_enable !== 1'b1 || unsync_bus !== 8'hC3) begin
         errors++; $display("[TB] FAIL midrst_setup got gid=%b en=%b bus=%h want 1/1/C3", grant_id, bus_enable, unsync_bus);
      end
      tick();
      #2 RST = 1'b1;
      #1;
      checks++; if ({unsync_bus, bus_enable, grant_id, busy} !== 11'h000) begin
         errors++; $display("[TB] FAIL midrst_clear got bus=%h en=%b gid=%b busy=%b want all 0",
                            unsync_bus, bus_enable, grant_id, busy);
      end
      #1 RST = 1'b0;
      tick();
      req_valid = 2'b10; req_data = 16'h3C00;
      #1;
      checks++; if (req_ready !== 2'b10) begin
         errors++; $display("[TB] FAIL midrst_ready got %b want 10", req_ready);
      end
      tick();
      req_valid = 2'b00;
      checks++; if (grant_id !== 1'b1 || unsync_bus !== 8'h3C || bus_enable !== 1'b1) begin
         errors++; $display("[TB] FAIL midrst_regrant got gid=%b bus=%h en=%b want 1/3C/1", grant_id, unsync_bus, bus_enable);
      end
      repeat (7) tick();
   endtask

   task automatic test_busy_stimulus();
      pulse_reset();
      req_valid = 2'b01; req_data = 16'h0077;
      tick();
      for (int k = 1; k <= 6; k++) begin
         req_data[7:0] = 8'(k * 17);
         req_valid[1]  = k[0];
         #1;
         checks++; if (unsync_bus !== 8'h77 || req_ready !== 2'b00) begin
            errors++; $display("[TB] FAIL busy_stim cycle %0d got bus=%h ready=%b want 77/00", k, unsync_bus, req_ready);
         end
         tick();
      end
      req_valid = 2'b00;
      #1;
      checks++; if (busy !== 1'b0 || unsync_bus !== 8'h77) begin
         errors++; $display("[TB] FAIL busy_idle_hold got busy=%b bus=%h want 0/77", busy, unsync_bus);
      end
      tick();
   endtask

   task automatic test_boundary();
      pulse_reset();
      req_valid_b = 2'b01; req_data_b = 16'h005E;
      #1;
      checks++; if (req_ready_b !== 2'b01) begin
         errors++; $display("[TB] FAIL bound_ready0 got %b want 01", req_ready_b);
      end
      tick();
      for (int k = 1; k <= 12; k++) begin
         checks++; if (bus_enable_b !== (k % 3 == 1) || xfer_done_b !== (k % 3 == 2)) begin
            errors++; $display("[TB] FAIL bound_timing cycle %0d got en=%b done=%b want %b/%b",
                               k, bus_enable_b, xfer_done_b, (k % 3 == 1), (k % 3 == 2));
         end
         checks++; if (req_ready_b !== ((k % 3 == 0) ? 2'b01 : 2'b00) || unsync_bus_b !== 8'h5E) begin
            errors++; $display("[TB] FAIL bound_ready cycle %0d got ready=%b bus=%h", k, req_ready_b, unsync_bus_b);
         end
         tick();
      end
      req_valid_b = 2'b00;
      repeat (3) tick();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_single();
      test_simultaneous();
      test_rr_fairness();
      test_reset_mid();
      test_busy_stimulus();
      test_boundary();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
